// File: rtl/lock_pkg.sv
// lock_pkg: FSM states, external counter commands and the factory code for lock_sequencer.
package lock_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_FAIL,
    S_OPEN,
    S_LOCKOUT,
    S_PROGRAM
  } state_t;
  localparam logic [1:0] CNT_HOLD = 2'b00;
  localparam logic [1:0] CNT_INC = 2'b01;
  localparam logic [1:0] CNT_CLR = 2'b11;
  localparam logic [19:0] DEFAULT_CODE = {5'd1, 5'd2, 5'd3, 5'd4};
  // digit i of the factory code, leftmost digit first
  function automatic logic [4:0] default_digit(input int i);
    return DEFAULT_CODE[19-5*(i%4)-:5];
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter with a done flag, shared by the OPEN and LOCKOUT periods.
module lock_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: digit-entry combination lock with failed-attempt lockout.
// Defining LOCK_PROGRAM_EN adds code reprogramming from OPEN via set_mode.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 16,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [4:0] digit,
  input  logic       clr,
  input  logic       set_mode,
  input  logic [4:0] cnt_value,
  output logic       cnt_en,
  output logic [1:0] cnt_sel,
  output logic       unlocked,
  output logic       alarm,
  output logic       busy
);
  localparam int IW = CODE_LEN > 1 ? $clog2(CODE_LEN) : 1;
  localparam int TW = $clog2((OPEN_CYCLES > LOCKOUT_CYCLES ? OPEN_CYCLES : LOCKOUT_CYCLES) + 1);
  state_t state, nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [4:0] entry[CODE_LEN];
  logic [4:0] code[CODE_LEN];
  logic in_seq, store, last, match, done, load, lock_trip;
  logic [TW-1:0] load_val;
  assign in_seq = state == S_ENTRY || state == S_PROGRAM;
  // clr beats a simultaneous digit while a sequence is in progress
  assign store = digit_valid && (state == S_IDLE || (in_seq && !clr));
  assign last = idx == IW'(CODE_LEN - 1);
  assign idx_nxt = store && !last ? idx + 1'b1 : (in_seq && !clr && !store ? idx : '0);
  assign lock_trip = {1'b0, cnt_value} + 6'd1 >= 6'(MAX_TRIES);
  assign busy = state != S_IDLE;
  assign load = nxt != state && (nxt == S_OPEN || nxt == S_LOCKOUT);
  assign load_val = nxt == S_OPEN ? TW'(OPEN_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < CODE_LEN; i++) if (entry[i] != code[i]) match = 1'b0;
  end
  always_comb begin
    nxt = state;
    cnt_en = 1'b0;
    cnt_sel = CNT_HOLD;
    case (state)
      S_IDLE: nxt = digit_valid ? S_ENTRY : S_IDLE;
      S_ENTRY: nxt = clr ? S_IDLE : (store && last ? S_CHECK : S_ENTRY);
      S_CHECK: begin
        nxt = match ? S_OPEN : S_FAIL;
        cnt_en = match;
        cnt_sel = match ? CNT_CLR : CNT_HOLD;
      end
      S_FAIL: begin
        nxt = lock_trip ? S_LOCKOUT : S_IDLE;
        cnt_en = 1'b1;
        cnt_sel = CNT_INC;
      end
`ifdef LOCK_PROGRAM_EN
      S_OPEN: nxt = set_mode ? S_PROGRAM : (done ? S_IDLE : S_OPEN);
      S_PROGRAM: nxt = clr || (store && last) ? S_IDLE : S_PROGRAM;
`else
      S_OPEN: nxt = done ? S_IDLE : S_OPEN;
`endif
      S_LOCKOUT: begin
        nxt = done ? S_IDLE : S_LOCKOUT;
        cnt_en = done;
        cnt_sel = done ? CNT_CLR : CNT_HOLD;
      end
      default: nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      idx <= '0;
      unlocked <= 1'b0;
      alarm <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) entry[i] <= '0;
    end else begin
      state <= nxt;
      idx <= idx_nxt;
      unlocked <= nxt == S_OPEN;
      alarm <= nxt == S_LOCKOUT;
      if (store) entry[idx] <= digit;
    end
`ifdef LOCK_PROGRAM_EN
  // new code is staged in entry and committed on the last digit so clr keeps the old one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < CODE_LEN; i++) code[i] <= default_digit(i);
    else if (state == S_PROGRAM && store && last)
      for (int i = 0; i < CODE_LEN; i++) code[i] <= (i == CODE_LEN - 1) ? digit : entry[i];
`else
  for (genvar g = 0; g < CODE_LEN; g++) begin : g_code
    assign code[g] = default_digit(g);
  end
  logic unused_set_mode;
  assign unused_set_mode = set_mode;
`endif
  lock_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .done(done)
  );
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: scoreboard bench; stimulus queues expected counter pulses and open/alarm lengths, a monitor pops them.
module tb_lock_sequencer;
  logic clk = 0, rst_n = 0, digit_valid = 0, clr = 0, set_mode = 0;
  logic [4:0] digit = 0, cnt_value = 0;
  logic cnt_en, unlocked, alarm, busy;
  logic [1:0] cnt_sel;
  int checks = 0, errors = 0;
  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t q[$];
  localparam int EV_CNT = 0, EV_UNL = 1, EV_ALM = 2;
  always #5 clk = ~clk;
  lock_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit_valid(digit_valid),
    .digit(digit),
    .clr(clr),
    .set_mode(set_mode),
    .cnt_value(cnt_value),
    .cnt_en(cnt_en),
    .cnt_sel(cnt_sel),
    .unlocked(unlocked),
    .alarm(alarm),
    .busy(busy)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_ev(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val = v;
    q.push_back(e);
  endtask
  task automatic pop_cmp(input string name, input int k, input int v);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s actual kind %0d value %0d expected no event", name, k, v);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val != v) begin
        errors++;
        $display("FAIL %s actual kind %0d value %0d expected kind %0d value %0d", name, k, v, e.kind, e.val);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask
  task automatic key(input int d);
    digit = 5'(d);
    digit_valid = 1;
    tick();
    digit_valid = 0;
  endtask
  task automatic code4(input int a, input int b, input int c, input int d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask
  task automatic async_reset(input string tag);
    #1 rst_n = 0;
    #1;
    chk({tag, "_unlocked"}, unlocked, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt_en"}, cnt_en, 0);
    @(negedge clk);
    #2 rst_n = 1;
    tick();
  endtask
  // counter pulses carry {unlocked, alarm, cnt_sel}; open/alarm runs are scored when they end
  initial begin
    int urun, arun;
    urun = 0;
    arun = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        urun = 0;
        arun = 0;
      end else begin
        if (cnt_en) pop_cmp("cnt_pulse", EV_CNT, int'({unlocked, alarm, cnt_sel}));
        if (unlocked) urun++;
        else if (urun != 0) begin
          pop_cmp("open_len", EV_UNL, urun);
          urun = 0;
        end
        if (alarm) arun++;
        else if (arun != 0) begin
          pop_cmp("alarm_len", EV_ALM, arun);
          arun = 0;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #3;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_sel", cnt_sel, 0);
    #10;
    @(negedge clk) rst_n = 1;
    tick();
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(1, 2, 3, 4);
    wait_n(20);
    chk("open_then_idle", busy, 0);
    expect_ev(EV_CNT, 1);
    code4(1, 2, 3, 5);
    wait_n(3);
    chk("fail_idle_busy", busy, 0);
    chk("fail_idle_alarm", alarm, 0);
    cnt_value = 1;
    expect_ev(EV_CNT, 1);
    code4(4, 3, 2, 1);
    wait_n(3);
    cnt_value = 0;
    chk("below_max_alarm", alarm, 0);
    chk("below_max_busy", busy, 0);
    cnt_value = 2;
    expect_ev(EV_CNT, 1);
    expect_ev(EV_CNT, 7);
    expect_ev(EV_ALM, 32);
    code4(1, 2, 4, 4);
    for (int i = 0; i < 32; i++) begin
      digit_valid = (i % 2 == 0);
      digit = 5'(i % 4 + 1);
      clr = (i % 5 == 3);
      set_mode = (i % 3 == 1);
      tick();
    end
    digit_valid = 0;
    clr = 0;
    set_mode = 0;
    cnt_value = 0;
    chk("lockout_alarm", alarm, 1);
    chk("lockout_busy", busy, 1);
    wait_n(4);
    chk("lockout_over_alarm", alarm, 0);
    chk("lockout_over_busy", busy, 0);
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(1, 2, 3, 4);
    wait_n(20);
    cnt_value = 31;
    expect_ev(EV_CNT, 1);
    expect_ev(EV_CNT, 7);
    expect_ev(EV_ALM, 32);
    code4(2, 2, 2, 2);
    wait_n(40);
    cnt_value = 0;
    chk("cnt31_done_busy", busy, 0);
    key(1);
    key(2);
    chk("entry_busy", busy, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("clr_idle", busy, 0);
    key(1);
    clr = 1;
    digit_valid = 1;
    digit = 2;
    tick();
    clr = 0;
    digit_valid = 0;
    chk("clr_wins_idle", busy, 0);
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(1, 2, 3, 4);
    wait_n(20);
    expect_ev(EV_CNT, 3);
    code4(1, 2, 3, 4);
    wait_n(5);
    chk("pre_reset_unlocked", unlocked, 1);
    async_reset("rst_open");
    cnt_value = 2;
    expect_ev(EV_CNT, 1);
    code4(1, 1, 1, 1);
    wait_n(2);
    cnt_value = 0;
    wait_n(8);
    chk("pre_reset_alarm", alarm, 1);
    async_reset("rst_lockout");
    key(1);
    key(2);
    async_reset("rst_partial");
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(1, 2, 3, 4);
    wait_n(20);
`ifdef LOCK_PROGRAM_EN
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 3);
    code4(1, 2, 3, 4);
    wait_n(3);
    set_mode = 1;
    tick();
    set_mode = 0;
    chk("program_unlocked", unlocked, 0);
    chk("program_busy", busy, 1);
    code4(9, 8, 7, 6);
    chk("program_done_busy", busy, 0);
    expect_ev(EV_CNT, 1);
    code4(1, 2, 3, 4);
    wait_n(3);
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(9, 8, 7, 6);
    wait_n(20);
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 3);
    code4(9, 8, 7, 6);
    wait_n(3);
    set_mode = 1;
    tick();
    set_mode = 0;
    key(5);
    key(5);
    clr = 1;
    tick();
    clr = 0;
    chk("program_abort_busy", busy, 0);
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(9, 8, 7, 6);
    wait_n(20);
`else
    expect_ev(EV_CNT, 3);
    expect_ev(EV_UNL, 16);
    code4(1, 2, 3, 4);
    wait_n(3);
    set_mode = 1;
    tick();
    set_mode = 0;
    chk("set_mode_ignored", unlocked, 1);
    wait_n(17);
`endif
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 The block SHALL provide parameter CODE_LEN, default 4, the number of digits per combination.
REQ-002 The block SHALL provide parameter MAX_TRIES, default 3, the number of consecutive failed attempts that triggers lockout.
REQ-003 The block SHALL provide parameter OPEN_CYCLES, default 16, the number of cycles unlocked stays high.
REQ-004 The block SHALL provide parameter LOCKOUT_CYCLES, default 32, the number of cycles of the lockout period.
REQ-005 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 RST_N  input  1  SHALL be the reset, asynchronous and active-low.
REQ-007 digit_valid  input  1  SHALL be a one-cycle strobe qualifying digit.
REQ-008 digit  input  5  SHALL be the entered digit value.
REQ-009 clr  input  1  SHALL abort the entry in progress.
REQ-010 set_mode  input  1  SHALL request code reprogramming; it is honoured only in OPEN and only when LOCK_PROGRAM_EN is defined.
REQ-011 cnt_value  input  5  SHALL be the failed-attempt count read back from the external Lock_Counter.
REQ-012 cnt_en  output  1  SHALL be the enable to the external Lock_Counter.
REQ-013 cnt_sel  output  2  SHALL be the command to the external Lock_Counter: 00 hold, 01 increment, 11 clear.
REQ-014 unlocked  output  1  SHALL be high while the lock is open.
REQ-015 alarm  output  1  SHALL be high during lockout.
REQ-016 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT and PROGRAM.
REQ-018 IDLE: digit_valid SHALL store the digit at index 0, set idx=1 and move to ENTRY.
REQ-019 ENTRY: digit_valid SHALL store the digit at idx and increment idx; the digit at index CODE_LEN-1 SHALL move the FSM to CHECK on the next cycle.
REQ-020 ENTRY: clr SHALL return the FSM to IDLE with idx=0 and no attempt counted; if clr and digit_valid are high in the same cycle, clr wins.
REQ-021 CHECK SHALL last 1 cycle and compare all CODE_LEN stored digits against the code register.
REQ-022 CHECK, on a match: the FSM SHALL move to OPEN and drive cnt_en=1, cnt_sel=11 for that cycle.
REQ-023 CHECK, on a mismatch: the FSM SHALL move to FAIL.
REQ-024 FAIL SHALL last 1 cycle and drive cnt_en=1, cnt_sel=01.
REQ-025 FAIL: if cnt_value+1 >= MAX_TRIES the FSM SHALL move to LOCKOUT, otherwise to IDLE; the comparison SHALL be 6 bits wide so a count of 31 does not wrap.
REQ-026 OPEN SHALL hold unlocked=1 for exactly OPEN_CYCLES cycles, then move to IDLE.
REQ-027 LOCKOUT SHALL hold alarm=1 for exactly LOCKOUT_CYCLES cycles; on its final cycle it SHALL drive cnt_en=1, cnt_sel=11, then move to IDLE.
REQ-028 digit_valid, clr and set_mode SHALL be ignored in CHECK, FAIL and LOCKOUT.
REQ-029 In all cycles not named in REQ-022, REQ-024 and REQ-027, the block SHALL drive cnt_en=0 and cnt_sel=00.
REQ-030 unlocked and alarm SHALL be registered outputs asserted from the first cycle of their state.

Reset
REQ-031 While RST_N=0 the block SHALL hold state=IDLE, idx=0, timer=0, cnt_en=0, cnt_sel=00, unlocked=0, alarm=0 and busy=0.
REQ-032 While RST_N=0 the code register SHALL be loaded with DEFAULT_CODE = {1,2,3,4}.
REQ-033 Reset asserted mid-operation, including during OPEN or LOCKOUT, SHALL take effect immediately; a partial entry SHALL be discarded.

Configuration
REQ-034 With LOCK_PROGRAM_EN defined, set_mode=1 in OPEN SHALL move the FSM to PROGRAM and deassert unlocked.
REQ-035 In PROGRAM, the next CODE_LEN digit_valid digits SHALL overwrite the code register in order, then the FSM SHALL return to IDLE.
REQ-036 In PROGRAM, clr SHALL abort to IDLE and leave the old code unchanged.
REQ-037 With LOCK_PROGRAM_EN undefined, the PROGRAM state and the code-write logic SHALL be absent, set_mode SHALL be ignored, and the code SHALL be the constant DEFAULT_CODE.

Structure
REQ-038 Package lock_pkg SHALL hold the state enum, the cnt_sel encodings (CNT_HOLD, CNT_INC, CNT_CLR) and DEFAULT_CODE.
REQ-039 Sub-module lock_timer SHALL be a loadable down-counter with a done flag, shared by OPEN and LOCKOUT.

Verification
REQ-040 Enter 1,2,3,4 -> CHECK, then unlocked=1 for 16 cycles, with one cnt_sel=11 pulse at entry to OPEN.
REQ-041 Enter 1,2,3,5 with cnt_value=0 -> one cnt_sel=01 pulse, then IDLE with alarm=0.
REQ-042 Make a wrong entry with cnt_value=2 -> LOCKOUT, alarm=1 for 32 cycles, cnt_sel=11 on the last cycle, and digits ignored throughout.
REQ-043 Enter 1,2 then pulse clr -> IDLE with no cnt_en pulse; a following entry of 1,2,3,4 opens the lock.
REQ-044 With LOCK_PROGRAM_EN defined: open, assert set_mode, enter 9,8,7,6 -> 1,2,3,4 now fails and 9,8,7,6 opens.
REQ-045 Pulse RST_N low during OPEN and during LOCKOUT -> unlocked=0, alarm=0 and state=IDLE asynchronously.
